// File: rtl/noise_mixer_pwm_pkg.sv
// Shared types and widths for the noise mixer / PWM audio path.
package noise_pkg;

    localparam int PWM_W      = 8;
    localparam int LFSR_W     = 8;
    localparam int NUM_VOICES = 3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAPT = 2'd3
    } seq_state_t;

    // Clamp the 10-bit voice total into the 8-bit sample range.
    function automatic logic [PWM_W-1:0] sat8(input logic [9:0] s);
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/noise_mixer_pwm_if.sv
// Link between the mixer and the three upstream LFSR generators.
interface noise_mixer_pwm_if;
    import noise_pkg::*;

    logic [NUM_VOICES-1:0] lfsr_en;
    logic [LFSR_W-1:0]     lfsr1;
    logic [LFSR_W-1:0]     lfsr2;
    logic [LFSR_W-1:0]     lfsr3;

    modport master (output lfsr_en, input lfsr1, lfsr2, lfsr3);
    modport slave  (input lfsr_en, output lfsr1, lfsr2, lfsr3);

endinterface

// File: rtl/noise_mixer_pwm_core.sv
// PWM period counter and duty comparator; duty reloads only at period boundaries.
module noise_pwm_core
    import noise_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [PWM_W-1:0] duty_in,
    input  logic             load,
    output logic [PWM_W-1:0] cnt,
    output logic             pwm_out
);

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (tick) r_cnt <= r_cnt + 8'd1;
            if (load) r_duty <= duty_in;
            r_pwm <= (r_cnt < r_duty);
        end
    end

    assign cnt     = r_cnt;
    assign pwm_out = r_pwm;

endmodule

// File: rtl/noise_mixer_pwm.sv
// Noise mixer: once per PWM period, strobe the enabled LFSRs, sum, saturate, attenuate.
//   state | meaning
//   RUN   | idle, waiting for the PWM period boundary
//   REQ   | advance strobe to the voices latched at the boundary
//   WAIT  | LFSR outputs settle after advancing
//   CAPT  | sum/saturate/shift into sample
module noise_mixer_pwm
    import noise_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_VOICES-1:0] key_en,
    input  logic [1:0]            vol,
    noise_mixer_pwm_if.master     lfsr,
    output logic [PWM_W-1:0]      sample,
    output logic                  sample_valid,
    output logic                  pwm_out
);

    seq_state_t            r_state;
    seq_state_t            w_next;
    logic [7:0]            r_pre;
    logic [NUM_VOICES-1:0] r_key_lat;
    logic [PWM_W-1:0]      r_sample;
    logic                  r_sample_valid;
    logic                  w_tick;
    logic                  w_boundary;
    logic [PWM_W-1:0]      w_cnt;
    logic [NUM_VOICES-1:0] w_lfsr_en;
    logic                  w_capt;
    logic [9:0]            w_sum;
    logic [PWM_W-1:0]      w_sat;

    assign w_tick     = (r_pre == 8'(PRESCALE - 1));
    assign w_boundary = w_tick && (w_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pre <= '0;
        else        r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:  if (w_boundary) w_next = ST_REQ;
            ST_REQ:  w_next = ST_WAIT;
            ST_WAIT: w_next = ST_CAPT;
            ST_CAPT: w_next = ST_RUN;
            default: w_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_lfsr_en = '0;
        w_capt    = 1'b0;
        case (r_state)
            ST_REQ:  w_lfsr_en = r_key_lat;
            ST_CAPT: w_capt = 1'b1;
            default: ;
        endcase
    end

    assign w_sum = 10'(r_key_lat[0] ? lfsr.lfsr1 : 8'h00)
                 + 10'(r_key_lat[1] ? lfsr.lfsr2 : 8'h00)
                 + 10'(r_key_lat[2] ? lfsr.lfsr3 : 8'h00);
    assign w_sat = sat8(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_lat      <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_boundary) r_key_lat <= key_en;
            if (w_capt)     r_sample  <= w_sat >> vol;
            r_sample_valid <= w_capt;
        end
    end

    noise_pwm_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (w_tick),
        .duty_in (r_sample),
        .load    (w_boundary),
        .cnt     (w_cnt),
        .pwm_out (pwm_out)
    );

    assign lfsr.lfsr_en = w_lfsr_en;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_noise_mixer_pwm.sv
// Directed bench for noise_mixer_pwm: one PRESCALE=1 instance plus a PRESCALE=4 instance for strobe spacing.
module tb_noise_mixer_pwm;
    import noise_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rst_n4 = 1'b0;
    logic [2:0] key_en  = 3'b000;
    logic [2:0] key_en4 = 3'b000;
    logic [1:0] vol  = 2'd0;
    logic [1:0] vol4 = 2'd0;
    logic [7:0] sample, sample4;
    logic       sample_valid, sample_valid4;
    logic       pwm_out, pwm_out4;

    int n_pass = 0;
    int n_tot  = 0;

    noise_mixer_pwm_if u_if ();
    noise_mixer_pwm_if u_if4 ();

    noise_mixer_pwm #(.PRESCALE(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_en       (key_en),
        .vol          (vol),
        .lfsr         (u_if.master),
        .sample       (sample),
        .sample_valid (sample_valid),
        .pwm_out      (pwm_out)
    );

    noise_mixer_pwm #(.PRESCALE(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n4),
        .key_en       (key_en4),
        .vol          (vol4),
        .lfsr         (u_if4.master),
        .sample       (sample4),
        .sample_valid (sample_valid4),
        .pwm_out      (pwm_out4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Step until sample_valid, recording any strobe seen on the way.
    task automatic wait_valid(output int cyc, output logic [2:0] stb, output int sc, output int sn);
        cyc = 0;
        stb = 3'b000;
        sc  = -1;
        sn  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (u_if.lfsr_en !== 3'b000) begin
                stb = u_if.lfsr_en;
                sc  = cyc;
                sn++;
            end
        end while (sample_valid !== 1'b1 && cyc < 600);
    endtask

    task automatic do_seq(input string tag, input logic [2:0] es, input logic [7:0] esmp,
                          output int cyc, output int sc);
        logic [2:0] stb;
        int         sn;
        wait_valid(cyc, stb, sc, sn);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
        chk({tag, "_stb"}, 32'(stb), 32'(es));
        chk({tag, "_nstb"}, 32'(sn), 32'(es != 3'b000));
        if (es != 3'b000) chk({tag, "_lat"}, 32'(cyc - sc), 32'd3);
        chk({tag, "_sample"}, 32'(sample), 32'(esmp));
    endtask

    task automatic wait_strobe(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (u_if.lfsr_en === 3'b000 && c < 600);
    endtask

    task automatic count_pwm(output int ones);
        ones = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out === 1'b1) ones++;
        end
    endtask

    initial begin
        int cyc, sc, ones, c;

        u_if.lfsr1  = 8'hFF;
        u_if.lfsr2  = 8'h00;
        u_if.lfsr3  = 8'h00;
        u_if4.lfsr1 = 8'h55;
        u_if4.lfsr2 = 8'h00;
        u_if4.lfsr3 = 8'h00;
        key_en  = 3'b001;
        key_en4 = 3'b001;

        repeat (2) @(negedge clk);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_lfsr_en", 32'(u_if.lfsr_en), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        rst_n = 1'b1;

        // single voice at full scale; first boundary 256 cycles after release
        do_seq("t1", 3'b001, 8'hFF, cyc, sc);
        chk("t1_first_strobe_cyc", 32'(sc), 32'd256);
        chk("t1_valid_cyc", 32'(cyc), 32'd259);
        do_seq("t1b", 3'b001, 8'hFF, cyc, sc);
        count_pwm(ones);
        chk("pwm_ff_ones", 32'(ones), 32'd255);

        key_en = 3'b111;
        u_if.lfsr1 = 8'h80;
        u_if.lfsr2 = 8'h80;
        u_if.lfsr3 = 8'h80;
        do_seq("sat384", 3'b111, 8'hFF, cyc, sc);

        vol = 2'd2;
        do_seq("sat_vol2", 3'b111, 8'h3F, cyc, sc);

        key_en = 3'b011;
        vol = 2'd1;
        u_if.lfsr1 = 8'h12;
        u_if.lfsr2 = 8'h34;
        do_seq("mix011_v1", 3'b011, 8'h23, cyc, sc);

        key_en = 3'b110;
        vol = 2'd3;
        u_if.lfsr2 = 8'h40;
        u_if.lfsr3 = 8'h21;
        do_seq("mix110_v3", 3'b110, 8'h0C, cyc, sc);

        // all voices muted: no strobe, zero sample, silent output next period
        key_en = 3'b000;
        vol = 2'd0;
        do_seq("mute", 3'b000, 8'h00, cyc, sc);
        do_seq("mute2", 3'b000, 8'h00, cyc, sc);
        count_pwm(ones);
        chk("pwm_zero_ones", 32'(ones), 32'd0);

        // key_en and lfsr3 change during WAIT must not disturb the capture
        key_en = 3'b011;
        u_if.lfsr1 = 8'h10;
        u_if.lfsr2 = 8'h20;
        u_if.lfsr3 = 8'h40;
        wait_strobe(c);
        chk("swap_stb", 32'(u_if.lfsr_en), 32'(3'b011));
        @(negedge clk);
        key_en = 3'b100;
        u_if.lfsr3 = 8'h7F;
        wait_valid(cyc, c, sc, ones);
        chk("swap_valid_cyc", 32'(cyc), 32'd2);
        chk("swap_sample", 32'(sample), 32'h30);

        // reset in WAIT aborts the sequence
        wait_strobe(c);
        chk("rstw_stb", 32'(u_if.lfsr_en), 32'(3'b100));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_sample", 32'(sample), 32'd0);
        chk("rstw_valid", 32'(sample_valid), 32'd0);
        chk("rstw_lfsr_en", 32'(u_if.lfsr_en), 32'd0);
        chk("rstw_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_seq("post_rst", 3'b100, 8'h7F, cyc, sc);
        chk("post_rst_strobe_cyc", 32'(sc), 32'd256);
        chk("post_rst_valid_cyc", 32'(cyc), 32'd259);

        // PRESCALE=4: strobes 1024 cycles apart
        @(negedge clk);
        rst_n4 = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (u_if4.lfsr_en === 3'b000 && c < 2000);
        chk("ps4_first_strobe", 32'(c), 32'd1024);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (u_if4.lfsr_en === 3'b000 && c < 2000);
        chk("ps4_spacing", 32'(c), 32'd1024);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
